// File: rtl/mdu_pkg.sv
// Shared types and constants for the RV64M multiply/divide sequencer.
package mdu_pkg;

   localparam int unsigned XLEN  = 64;
   localparam int unsigned CNT_W = 7;

   localparam logic [CNT_W-1:0] N_FULL = 7'd64;
   localparam logic [CNT_W-1:0] N_WORD = 7'd32;

   typedef enum logic [2:0] {
      OpMul,
      OpMulh,
      OpMulhsu,
      OpMulhu,
      OpDiv,
      OpDivu,
      OpRem,
      OpRemu
   } mdu_op_e;

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StDone
   } state_e;

   function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
      return {{(XLEN-32){v[31]}}, v[31:0]};
   endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One radix-2 restoring division iteration: shift {rem,quo} left, trial-subtract the divisor.
module mdu_div_step
   import mdu_pkg::*;
(
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] div_i,
   output logic [XLEN-1:0] rem_o,
   output logic [XLEN-1:0] quo_o
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;
   logic          ge;

   always_comb begin
      shifted = {rem_i, quo_i[XLEN-1]};
      diff    = shifted - {1'b0, div_i};
      ge      = (shifted >= {1'b0, div_i});
      rem_o   = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      quo_o   = {quo_i[XLEN-2:0], ge};
   end

endmodule

// File: rtl/mdu_seq.sv
// Iterative RV64M multiply/divide sequencer with valid/ready issue and writeback handshakes.
// Optional FAST_MUL_EN: multiplies use a single-cycle 65x65 product instead of shift/add.
module mdu_seq
   import mdu_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [2:0]      in_op_i,
   input  logic            in_word_i,
   input  logic [XLEN-1:0] in_a_i,
   input  logic [XLEN-1:0] in_b_i,
   input  logic            flush_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] out_result_o,
   output logic            busy_o
);

   state_e            state_q;
   mdu_op_e           op_q;
   logic              word_q, neg_q, rneg_q, out_valid_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [XLEN-1:0]   hi_q, lo_q, b_q, result_q;

   mdu_op_e           op;
   logic              is_mulh, is_div, is_rem, word, a_sgn, b_sgn, a_neg, b_neg;
   logic              div_zero, div_ovf;
   logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, most_neg, spec_res;

   always_comb begin
      op       = mdu_op_e'(in_op_i);
      is_mulh  = op inside {OpMulh, OpMulhsu, OpMulhu};
      is_div   = in_op_i[2];
      is_rem   = op inside {OpRem, OpRemu};
      word     = in_word_i & ~is_mulh;
      a_sgn    = op inside {OpMulh, OpMulhsu, OpDiv, OpRem};
      b_sgn    = op inside {OpMulh, OpDiv, OpRem};
      a_ext    = word ? (a_sgn ? sext32(in_a_i) : {32'b0, in_a_i[31:0]}) : in_a_i;
      b_ext    = word ? (b_sgn ? sext32(in_b_i) : {32'b0, in_b_i[31:0]}) : in_b_i;
      a_neg    = a_sgn & a_ext[XLEN-1];
      b_neg    = b_sgn & b_ext[XLEN-1];
      a_mag    = a_neg ? -a_ext : a_ext;
      b_mag    = b_neg ? -b_ext : b_ext;
      most_neg = word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
      div_zero = is_div & (b_ext == '0);
      div_ovf  = is_div & a_sgn & (a_ext == most_neg) & (&b_ext);
      if (div_zero) spec_res = is_rem ? a_ext : '1;
      else          spec_res = is_rem ? '0 : a_ext;
      if (word) spec_res = sext32(spec_res);
   end

`ifdef FAST_MUL_EN
   logic signed [2*XLEN-1:0] fa, fb, fp;
   logic [XLEN-1:0]          fast_res;

   always_comb begin
      fa       = {{XLEN{a_sgn & a_ext[XLEN-1]}}, a_ext};
      fb       = {{XLEN{b_sgn & b_ext[XLEN-1]}}, b_ext};
      fp       = fa * fb;
      fast_res = (op == OpMul) ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
      if (word) fast_res = sext32(fast_res);
   end
`endif

   logic [XLEN-1:0]   dv_rem, dv_quo;

   mdu_div_step u_div_step (
      .rem_i (hi_q),
      .quo_i (lo_q),
      .div_i (b_q),
      .rem_o (dv_rem),
      .quo_o (dv_quo)
   );

   logic [XLEN:0]     mul_sum;
   logic [XLEN-1:0]   hi_nx, lo_nx, quo, rem, calc_res;
   logic [2*XLEN-1:0] mul_p;
   logic              last;

   always_comb begin
      // Shift/add: {carry,hi,lo} >> 1 after conditionally adding the multiplicand into hi.
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      hi_nx   = op_q[2] ? dv_rem : mul_sum[XLEN:1];
      lo_nx   = op_q[2] ? dv_quo : {mul_sum[0], lo_q[XLEN-1:1]};
      last    = (cnt_q == ((word_q ? N_WORD : N_FULL) - CNT_W'(1)));
      // After 32 steps the product sits 32 bits up in {hi,lo}.
      mul_p   = word_q ? {32'b0, hi_nx, lo_nx[XLEN-1:32]} : {hi_nx, lo_nx};
      if (neg_q) mul_p = -mul_p;
      quo     = neg_q ? -lo_nx : lo_nx;
      rem     = rneg_q ? -hi_nx : hi_nx;
      unique case (op_q)
         OpMul:                     calc_res = mul_p[XLEN-1:0];
         OpMulh, OpMulhsu, OpMulhu: calc_res = mul_p[2*XLEN-1:XLEN];
         OpDiv, OpDivu:             calc_res = quo;
         default:                   calc_res = rem;
      endcase
      if (word_q) calc_res = sext32(calc_res);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         op_q        <= OpMul;
         word_q      <= 1'b0;
         neg_q       <= 1'b0;
         rneg_q      <= 1'b0;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         b_q         <= '0;
         result_q    <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid_i && !flush_i) begin
                  op_q   <= op;
                  word_q <= word;
                  neg_q  <= a_neg ^ b_neg;
                  rneg_q <= a_neg;
                  cnt_q  <= '0;
                  if (div_zero || div_ovf) begin
                     result_q    <= spec_res;
                     out_valid_q <= 1'b1;
                     state_q     <= StDone;
                  end
`ifdef FAST_MUL_EN
                  else if (!is_div) begin
                     result_q    <= fast_res;
                     out_valid_q <= 1'b1;
                     state_q     <= StDone;
                  end
`endif
                  else begin
                     hi_q    <= '0;
                     // W divides pre-shift the 32-bit dividend so 32 steps suffice.
                     lo_q    <= (is_div && word) ? {a_mag[31:0], 32'b0} : a_mag;
                     b_q     <= b_mag;
                     state_q <= StCalc;
                  end
               end
            end
            StCalc: begin
               if (flush_i) begin
                  state_q <= StIdle;
               end else begin
                  hi_q  <= hi_nx;
                  lo_q  <= lo_nx;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (last) begin
                     result_q    <= calc_res;
                     out_valid_q <= 1'b1;
                     state_q     <= StDone;
                  end
               end
            end
            StDone: begin
               if (flush_i || out_ready_i) begin
                  out_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign in_ready_o   = (state_q == StIdle);
   assign busy_o       = (state_q != StIdle);
   assign out_valid_o  = out_valid_q;
   assign out_result_o = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Randomized self-checking bench for mdu_seq against an arithmetic reference model.
module tb_mdu_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_word = 1'b0, flush = 1'b0, out_ready = 1'b0;
   logic [2:0]  in_op = 3'd0;
   logic [63:0] in_a = '0, in_b = '0;
   logic        in_ready, out_valid, busy;
   logic [63:0] out_result;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

   mdu_seq dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .in_op_i      (in_op),
      .in_word_i    (in_word),
      .in_a_i       (in_a),
      .in_b_i       (in_b),
      .flush_i      (flush),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .out_result_o (out_result),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, got, exp);
      end
   endtask

   function automatic logic is_word(input logic [2:0] op, input logic w);
      return w && !(op inside {3'd1, 3'd2, 3'd3});
   endfunction

   function automatic logic [63:0] model(input logic [2:0] op, input logic w,
                                         input logic [63:0] a, input logic [63:0] b);
      logic signed [127:0] p;
      logic signed [63:0]  sa, sb;
      logic signed [31:0]  x, y;
      logic [31:0]         ux, uy;
      logic [63:0]         r;
      logic                wd;
      wd = is_word(op, w);
      sa = a; sb = b; x = a[31:0]; y = b[31:0]; ux = a[31:0]; uy = b[31:0];
      r  = '0;
      case (op)
         3'd0: r = a * b;
         3'd1: begin p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); r = p[127:64]; end
         3'd2: begin p = $signed({{64{a[63]}}, a}) * $signed({64'b0, b}); r = p[127:64]; end
         3'd3: begin p = {64'b0, a} * {64'b0, b}; r = p[127:64]; end
         3'd4: begin
            if (wd) begin
               if (y == 0) r = '1;
               else if (x == 32'sh8000_0000 && y == -1) r[31:0] = x;
               else r[31:0] = x / y;
            end else begin
               if (b == 0) r = '1;
               else if (a == MIN64 && b == '1) r = a;
               else r = sa / sb;
            end
         end
         3'd5: begin
            if (wd) r = (uy == 0) ? '1 : {32'b0, ux / uy};
            else    r = (b == 0) ? '1 : a / b;
         end
         3'd6: begin
            if (wd) begin
               if (y == 0) r[31:0] = x;
               else if (x == 32'sh8000_0000 && y == -1) r = '0;
               else r[31:0] = x % y;
            end else begin
               if (b == 0) r = a;
               else if (a == MIN64 && b == '1) r = '0;
               else r = sa % sb;
            end
         end
         default: begin
            if (wd) r = (uy == 0) ? {32'b0, ux} : {32'b0, ux % uy};
            else    r = (b == 0) ? a : a % b;
         end
      endcase
      if (wd) r = {{32{r[31]}}, r[31:0]};
      return r;
   endfunction

   function automatic int lat_model(input logic [2:0] op, input logic w,
                                    input logic [63:0] a, input logic [63:0] b);
      logic wd, sgn, special;
      wd  = is_word(op, w);
      sgn = (op == 3'd4) || (op == 3'd6);
      if (op[2]) begin
         if (wd) special = (b[31:0] == 0) || (sgn && a[31:0] == 32'h8000_0000 && &b[31:0]);
         else    special = (b == 0) || (sgn && a == MIN64 && &b);
         return special ? 1 : (wd ? 33 : 65);
      end
`ifdef FAST_MUL_EN
      return 1;
`else
      return wd ? 33 : 65;
`endif
   endfunction

   task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b);
      @(negedge clk);
      in_valid = 1'b1; in_op = op; in_word = w; in_a = a; in_b = b;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic w,
                         input logic [63:0] a, input logic [63:0] b);
      int lat;
      check({tag, " rdy"}, 64'(in_ready), 64'd1);
      issue(op, w, a, b);
      wait_valid(lat);
      check({tag, " lat"}, 64'(lat), 64'(lat_model(op, w, a, b)));
      check({tag, " res"}, out_result, model(op, w, a, b));
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check({tag, " drop"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      int          lat, seen;
      logic [2:0]  op;
      logic        w;
      logic [63:0] a, b;

      #12;
      check("reset rdy", 64'(in_ready), 64'd1);
      check("reset vld", 64'(out_valid), 64'd0);
      check("reset res", out_result, 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      @(negedge clk) rst = 1'b0;

      run_op("div -7/2", 3'd4, 1'b0, -64'sd7, 64'd2);
      run_op("rem -7/2", 3'd6, 1'b0, -64'sd7, 64'd2);
      run_op("divw ovf", 3'd4, 1'b1, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF);
      run_op("divu /0", 3'd5, 1'b0, 64'd55, 64'd0);
      run_op("remu /0", 3'd7, 1'b0, 64'd123, 64'd0);
      run_op("div ovf", 3'd4, 1'b0, MIN64, '1);
      run_op("rem ovf", 3'd6, 1'b0, MIN64, '1);
      run_op("mulhu max", 3'd3, 1'b0, '1, '1);
      run_op("mulhsu", 3'd2, 1'b0, '1, 64'd2);
      run_op("mulw", 3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2);
      run_op("divuw", 3'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'd3);
      run_op("remw", 3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2);

      // Result must stay stable while writeback stalls; new offers are ignored.
      issue(3'd4, 1'b0, 64'd100, 64'd7);
      wait_valid(lat);
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_op = 3'd5; in_a = 64'd9; in_b = 64'd0;
         @(posedge clk);
         #1;
         check("hold vld", 64'(out_valid), 64'd1);
         check("hold res", out_result, 64'd14);
         check("hold rdy", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check("release vld", 64'(out_valid), 64'd0);
      check("release rdy", 64'(in_ready), 64'd1);

      // Flush on the 20th CALC edge.
      issue(3'd4, 1'b0, 64'd1000, 64'd3);
      repeat (19) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      check("flush rdy", 64'(in_ready), 64'd1);
      check("flush busy", 64'(busy), 64'd0);
      seen = 0;
      repeat (80) begin
         @(posedge clk);
         #1 if (out_valid) seen++;
      end
      check("flush no vld", 64'(seen), 64'd0);

      @(negedge clk);
      in_valid = 1'b1; flush = 1'b1; in_op = 3'd5; in_word = 1'b0; in_a = 64'd5; in_b = 64'd0;
      @(posedge clk);
      #1 in_valid = 1'b0; flush = 1'b0;
      check("flush acc rdy", 64'(in_ready), 64'd1);
      check("flush acc vld", 64'(out_valid), 64'd0);

      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         w  = 1'($urandom_range(0, 1));
         a  = {$urandom, $urandom};
         b  = {$urandom, $urandom};
         case ($urandom_range(0, 7))
            0: b = '0;
            1: begin
               if (w) begin a[31:0] = 32'h8000_0000; b[31:0] = '1; end
               else   begin a = MIN64; b = '1; end
            end
            2: begin a = 64'($urandom_range(0, 50)); b = 64'($urandom_range(1, 9)); end
            3: b = 64'($signed(-$urandom_range(1, 9)));
            default: ;
         endcase
         run_op("rand", op, w, a, b);
      end

      // Asynchronous reset while iterating; previous result is nonzero.
      issue(3'd4, 1'b0, 64'd77, 64'd5);
      repeat (10) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst rdy", 64'(in_ready), 64'd1);
      check("arst vld", 64'(out_valid), 64'd0);
      check("arst res", out_result, 64'd0);
      check("arst busy", 64'(busy), 64'd0);
      @(negedge clk) rst = 1'b0;
      run_op("post rst", 3'd7, 1'b0, 64'd77, 64'd5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
